vdp_ctrl_port: RTL and testbench



---
 rtl/vdp_ctrl_port.sv | 208 ++++++++++++++++++++
 tb/tb_vdp_ctrl_port.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_ctrl_port.sv
// Z80-facing VDP command/data port: decodes port accesses into VRAM, CRAM and
// register-file writes, runs VRAM read-ahead and keeps the status flags.
module vdp_ctrl_port #(
  parameter int ADDR_W = 14,
  parameter int CRAM_W = 5
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              vdp_go,
  input  logic              MODE,
  input  logic              CSW_L,
  input  logic              CSR_L,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic [7:0]        stat_out,
  input  logic              frame_pulse,
  input  logic              spr_ovf,
  input  logic              spr_coll,
  input  logic              irq_en,
  output logic              int_pend,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  output logic              vram_we,
  output logic              vram_re,
  input  logic              vram_grant,
  input  logic [7:0]        vram_rdata,
  output logic [CRAM_W-1:0] cram_addr,
  output logic [5:0]        cram_wdata,
  output logic              cram_we,
  output logic [3:0]        rf_addr,
  output logic [7:0]        rf_data,
  output logic              rf_en,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_VWR  = 2'd1,
    S_VRD  = 2'd2,
    S_VCAP = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic                r_go_q;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_code;
  logic                r_first_f;
  logic [7:0]          r_rbuf;
  logic                r_frame_f;
  logic                r_ovf_f;
  logic                r_coll_f;
  logic                r_cram_we;
  logic [CRAM_W-1:0]   r_cram_addr;
  logic [5:0]          r_cram_wdata;
  logic                r_rf_en;
  logic [3:0]          r_rf_addr;
  logic [7:0]          r_rf_data;

  logic w_take;
  logic w_cw;
  logic w_cw2;
  logic w_dw;
  logic w_dr;
  logic w_cr;
  logic w_addr_inc;

  // Accesses landing outside IDLE are dropped entirely.
  assign w_take = vdp_go & ~r_go_q & (r_state == S_IDLE);
  assign w_cw   = w_take &  MODE & ~CSW_L;
  assign w_dw   = w_take & ~MODE & ~CSW_L;
  assign w_dr   = w_take & ~MODE &  CSW_L & ~CSR_L;
  assign w_cr   = w_take &  MODE &  CSW_L & ~CSR_L;
  assign w_cw2  = w_cw & r_first_f;

  assign w_addr_inc = ((r_state == S_VWR) & vram_grant) | (r_state == S_VCAP) | r_cram_we;

  // Next-state decode for the VRAM request sequencer.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_dw && (r_code != 2'd3)) begin
          w_state_nx = S_VWR;
        end else if (w_dr || (w_cw2 && (data_in[7:6] == 2'd0))) begin
          w_state_nx = S_VRD;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_VWR: begin
        if (vram_grant) begin
          w_state_nx = S_IDLE;
        end else begin
          w_state_nx = S_VWR;
        end
      end
      S_VRD: begin
        if (vram_grant) begin
          w_state_nx = S_VCAP;
        end else begin
          w_state_nx = S_VRD;
        end
      end
      S_VCAP:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State register and access-edge detector.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state <= S_IDLE;
      r_go_q  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_go_q  <= vdp_go;
    end
  end

  // Address pointer, command code and two-byte command sequencing.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_addr    <= '0;
      r_code    <= 2'd0;
      r_first_f <= 1'b0;
    end else begin
      if (w_cw && !r_first_f) begin
        r_addr[7:0] <= data_in;
      end else if (w_cw2) begin
        r_addr <= {data_in[ADDR_W-9:0], r_addr[7:0]};
      end else if (w_addr_inc) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
      if (w_cw2) begin
        r_code <= data_in[7:6];
      end
      if (w_cw) begin
        r_first_f <= ~r_first_f;
      end else if (w_dw || w_dr || w_cr) begin
        r_first_f <= 1'b0;
      end
    end
  end

  // Read buffer: doubles as the VRAM write-data holding register.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_rbuf <= 8'h00;
    end else if (w_dw) begin
      r_rbuf <= data_in;
    end else if (r_state == S_VCAP) begin
      r_rbuf <= vram_rdata;
    end
  end

  // Single-cycle CRAM and register-file write strobes with their payloads.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_cram_we    <= 1'b0;
      r_cram_addr  <= '0;
      r_cram_wdata <= 6'd0;
      r_rf_en      <= 1'b0;
      r_rf_addr    <= 4'd0;
      r_rf_data    <= 8'h00;
    end else begin
      r_cram_we <= w_dw & (r_code == 2'd3);
      r_rf_en   <= w_cw2 & (data_in[7:6] == 2'd2);
      if (w_dw && (r_code == 2'd3)) begin
        r_cram_addr  <= r_addr[CRAM_W-1:0];
        r_cram_wdata <= data_in[5:0];
      end
      if (w_cw2 && (data_in[7:6] == 2'd2)) begin
        r_rf_addr <= data_in[3:0];
        r_rf_data <= r_addr[7:0];
      end
    end
  end

  // Status flags: an incoming event pulse beats a same-cycle status-read clear.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_frame_f <= 1'b0;
      r_ovf_f   <= 1'b0;
      r_coll_f  <= 1'b0;
    end else begin
      r_frame_f <= frame_pulse | (r_frame_f & ~w_cr);
      r_ovf_f   <= spr_ovf     | (r_ovf_f   & ~w_cr);
      r_coll_f  <= spr_coll    | (r_coll_f  & ~w_cr);
    end
  end

  assign data_out   = r_rbuf;
  assign stat_out   = {r_frame_f, r_ovf_f, r_coll_f, 5'b00000};
  assign int_pend   = r_frame_f & irq_en;
  assign vram_addr  = r_addr;
  assign vram_wdata = r_rbuf;
  assign vram_we    = (r_state == S_VWR);
  assign vram_re    = (r_state == S_VRD);
  assign cram_addr  = r_cram_addr;
  assign cram_wdata = r_cram_wdata;
  assign cram_we    = r_cram_we;
  assign rf_addr    = r_rf_addr;
  assign rf_data    = r_rf_data;
  assign rf_en      = r_rf_en;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_vdp_ctrl_port.sv
// Self-checking bench for vdp_ctrl_port: directed scenarios followed by random
// port traffic, all checked against a port-level behavioural model.
module tb_vdp_ctrl_port;

  localparam int K_NONE = 0;
  localparam int K_VWR  = 1;
  localparam int K_VRD  = 2;
  localparam int K_CRAM = 3;
  localparam int K_RF   = 4;

  logic        clk;
  logic        rst_L;
  logic        vdp_go, MODE, CSW_L, CSR_L;
  logic [7:0]  data_in, data_out, stat_out;
  logic        frame_pulse, spr_ovf, spr_coll, irq_en, int_pend;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata, vram_rdata;
  logic        vram_we, vram_re, vram_grant;
  logic [4:0]  cram_addr;
  logic [5:0]  cram_wdata;
  logic        cram_we;
  logic [3:0]  rf_addr;
  logic [7:0]  rf_data;
  logic        rf_en, busy;

  vdp_ctrl_port #(.ADDR_W(14), .CRAM_W(5)) dut (
    .clk(clk), .rst_L(rst_L), .vdp_go(vdp_go), .MODE(MODE), .CSW_L(CSW_L), .CSR_L(CSR_L),
    .data_in(data_in), .data_out(data_out), .stat_out(stat_out),
    .frame_pulse(frame_pulse), .spr_ovf(spr_ovf), .spr_coll(spr_coll),
    .irq_en(irq_en), .int_pend(int_pend),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we), .vram_re(vram_re),
    .vram_grant(vram_grant), .vram_rdata(vram_rdata),
    .cram_addr(cram_addr), .cram_wdata(cram_wdata), .cram_we(cram_we),
    .rf_addr(rf_addr), .rf_data(rf_data), .rf_en(rf_en), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // environment VRAM (written by the DUT) and the model's view of it
  logic [7:0]  vram     [0:16383];
  logic [7:0]  ref_vram [0:16383];
  int          gnt_wait = 0;
  int          req_cycles = 0;
  bit          rd_valid_next = 1'b0;
  logic [13:0] rd_addr_q = 14'd0;

  // model state
  logic [13:0] m_addr;
  logic [1:0]  m_code;
  bit          m_first, m_frame, m_ovf, m_coll;
  logic [7:0]  m_rbuf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_addr = 14'd0; m_code = 2'd0; m_first = 1'b0; m_rbuf = 8'h00;
    m_frame = 1'b0; m_ovf = 1'b0; m_coll = 1'b0;
  endtask

  // advance one cycle, then play the VRAM arbiter for the new cycle
  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_valid_next) vram_rdata = vram[rd_addr_q];
    else vram_rdata = 8'($urandom);
    rd_valid_next = 1'b0;
    vram_grant = 1'b0;
    if (vram_we || vram_re) begin
      req_cycles++;
      if (gnt_wait == 0) begin
        vram_grant = 1'b1;
        if (vram_we) vram[vram_addr] = vram_wdata;
        else begin
          rd_valid_next = 1'b1;
          rd_addr_q = vram_addr;
        end
      end else begin
        gnt_wait--;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && busy; i++) tick();
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic do_acc(input bit is_ctrl, input bit is_rd, input logic [7:0] d,
                        input int gw, input logic [2:0] pl);
    int         kind;
    logic [13:0] ea;
    logic [7:0] edo, est;
    logic [4:0] eca;
    logic [3:0] era;
    logic [7:0] erd;
    kind = K_NONE; ea = 14'd0; edo = m_rbuf; eca = 5'd0; era = 4'd0; erd = 8'd0;
    est = {m_frame, m_ovf, m_coll, 5'b00000};
    if (is_ctrl && !is_rd) begin
      if (!m_first) begin
        m_addr[7:0] = d;
        m_first = 1'b1;
      end else begin
        m_addr = {d[5:0], m_addr[7:0]};
        m_code = d[7:6];
        m_first = 1'b0;
        if (m_code == 2'd0) begin
          kind = K_VRD; ea = m_addr;
          m_rbuf = ref_vram[m_addr];
          m_addr = m_addr + 14'd1;
        end else if (m_code == 2'd2) begin
          kind = K_RF; era = d[3:0]; erd = m_addr[7:0];
        end
      end
    end else if (!is_ctrl && !is_rd) begin
      m_first = 1'b0;
      m_rbuf = d;
      if (m_code == 2'd3) begin
        kind = K_CRAM; eca = m_addr[4:0];
      end else begin
        kind = K_VWR; ea = m_addr;
        ref_vram[m_addr] = d;
      end
      m_addr = m_addr + 14'd1;
    end else if (!is_ctrl) begin
      m_first = 1'b0;
      kind = K_VRD; ea = m_addr;
      m_rbuf = ref_vram[m_addr];
      m_addr = m_addr + 14'd1;
    end else begin
      m_first = 1'b0;
      m_frame = 1'b0; m_ovf = 1'b0; m_coll = 1'b0;
    end
    m_frame = m_frame | pl[2];
    m_ovf   = m_ovf   | pl[1];
    m_coll  = m_coll  | pl[0];

    gnt_wait = gw; req_cycles = 0;
    vdp_go = 1'b1; MODE = is_ctrl; CSW_L = is_rd; CSR_L = !is_rd; data_in = d;
    {frame_pulse, spr_ovf, spr_coll} = pl;
    if (!is_ctrl && is_rd) check("rd_dout", 32'(data_out), 32'(edo));
    if (is_ctrl && is_rd) check("stat_rd", 32'(stat_out), 32'(est));
    tick();
    {frame_pulse, spr_ovf, spr_coll} = 3'b000;
    check("vram_we", 32'(vram_we), 32'(kind == K_VWR));
    check("vram_re", 32'(vram_re), 32'(kind == K_VRD));
    check("cram_we", 32'(cram_we), 32'(kind == K_CRAM));
    check("rf_en", 32'(rf_en), 32'(kind == K_RF));
    check("busy", 32'(busy), 32'((kind == K_VWR) || (kind == K_VRD)));
    if (kind == K_VWR || kind == K_VRD) check("vram_addr", 32'(vram_addr), 32'(ea));
    if (kind == K_VWR) check("vram_wdata", 32'(vram_wdata), 32'(d));
    if (kind == K_CRAM) begin
      check("cram_addr", 32'(cram_addr), 32'(eca));
      check("cram_wdata", 32'(cram_wdata), 32'(d[5:0]));
    end
    if (kind == K_RF) begin
      check("rf_addr", 32'(rf_addr), 32'(era));
      check("rf_data", 32'(rf_data), 32'(erd));
    end
    check("stat", 32'(stat_out), 32'({m_frame, m_ovf, m_coll, 5'b00000}));
    check("int_pend", 32'(int_pend), 32'(m_frame & irq_en));
    tick();
    vdp_go = 1'b0; MODE = 1'b0; CSW_L = 1'b1; CSR_L = 1'b1;
    check("rf_en_len", 32'(rf_en), 32'd0);
    check("cram_we_len", 32'(cram_we), 32'd0);
    wait_idle();
    if (kind == K_VWR || kind == K_VRD) check("req_len", 32'(req_cycles), 32'(gw + 1));
    check("rbuf", 32'(data_out), 32'(m_rbuf));
    tick();
  endtask

  initial begin
    logic [7:0] rb;
    int         sel;
    logic [2:0] pl;
    for (int i = 0; i < 16384; i++) begin
      rb = 8'($urandom);
      vram[i] = rb;
      ref_vram[i] = rb;
    end
    rst_L = 1'b0; vdp_go = 1'b0; MODE = 1'b0; CSW_L = 1'b1; CSR_L = 1'b1; data_in = 8'h00;
    frame_pulse = 1'b0; spr_ovf = 1'b0; spr_coll = 1'b0; irq_en = 1'b0;
    vram_grant = 1'b0; vram_rdata = 8'h00;
    model_reset();
    tick(); tick(); tick();
    check("rst_dout", 32'(data_out), 32'd0);
    check("rst_stat", 32'(stat_out), 32'd0);
    check("rst_strobes", 32'({vram_we, vram_re, cram_we, rf_en, busy, int_pend}), 32'd0);
    check("rst_vaddr", 32'(vram_addr), 32'd0);
    rst_L = 1'b1;
    tick();

    // VRAM write at 0x1234 with grant two cycles into the request
    do_acc(1'b1, 1'b0, 8'h34, 0, 3'b000);
    do_acc(1'b1, 1'b0, 8'h52, 0, 3'b000);
    do_acc(1'b0, 1'b0, 8'hAB, 2, 3'b000);
    check("w1_mem", 32'(vram[14'h1234]), 32'h0AB);
    do_acc(1'b0, 1'b0, 8'hCD, 1, 3'b000);
    check("w1_next", 32'(vram[14'h1235]), 32'h0CD);

    // register write
    do_acc(1'b1, 1'b0, 8'h07, 0, 3'b000);
    do_acc(1'b1, 1'b0, 8'h81, 0, 3'b000);

    // read setup at 0x3FFF wraps to 0x0000
    vram[14'h3FFF] = 8'h5A; ref_vram[14'h3FFF] = 8'h5A;
    do_acc(1'b1, 1'b0, 8'hFF, 0, 3'b000);
    do_acc(1'b1, 1'b0, 8'h3F, 0, 3'b000);
    check("wrap_dout", 32'(data_out), 32'h05A);
    do_acc(1'b0, 1'b1, 8'h00, 3, 3'b000);

    // CRAM write at 31 then wrap to 0
    do_acc(1'b1, 1'b0, 8'h1F, 0, 3'b000);
    do_acc(1'b1, 1'b0, 8'hC0, 0, 3'b000);
    do_acc(1'b0, 1'b0, 8'h3C, 0, 3'b000);
    do_acc(1'b0, 1'b0, 8'h15, 0, 3'b000);

    // frame flag, interrupt, clear on status read, and set-beats-clear
    irq_en = 1'b1;
    frame_pulse = 1'b1;
    tick();
    frame_pulse = 1'b0;
    m_frame = 1'b1;
    check("int_pend_set", 32'(int_pend), 32'd1);
    check("stat_frame", 32'(stat_out), 32'h080);
    do_acc(1'b1, 1'b1, 8'h00, 0, 3'b000);
    check("stat_clr", 32'(stat_out), 32'd0);
    do_acc(1'b1, 1'b1, 8'h00, 0, 3'b100);
    check("stat_setwins", 32'(stat_out), 32'h080);

    // data read cancels a pending first command byte
    do_acc(1'b1, 1'b0, 8'h00, 0, 3'b000);
    do_acc(1'b0, 1'b1, 8'h00, 0, 3'b000);
    do_acc(1'b1, 1'b0, 8'h55, 0, 3'b000);
    do_acc(1'b1, 1'b0, 8'h82, 0, 3'b000);
    check("first_cleared", 32'(rf_data), 32'h055);

    // reset while a read request is held
    gnt_wait = 200;
    vdp_go = 1'b1; MODE = 1'b0; CSW_L = 1'b1; CSR_L = 1'b0;
    tick(); tick();
    vdp_go = 1'b0; CSR_L = 1'b1;
    tick();
    check("pre_rst_re", 32'(vram_re), 32'd1);
    #2 rst_L = 1'b0;
    #1;
    check("async_rst_re", 32'(vram_re), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    tick();
    rst_L = 1'b1;
    gnt_wait = 0;
    model_reset();
    tick(); tick();
    check("post_rst_re", 32'(vram_re), 32'd0);
    check("post_rst_dout", 32'(data_out), 32'd0);
    do_acc(1'b0, 1'b0, 8'h99, 0, 3'b000);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      irq_en = 1'($urandom_range(0, 1));
      pl = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
      sel = $urandom_range(0, 9);
      if (sel <= 3)      do_acc(1'b1, 1'b0, 8'($urandom), $urandom_range(0, 3), pl);
      else if (sel <= 6) do_acc(1'b0, 1'b0, 8'($urandom), $urandom_range(0, 3), pl);
      else if (sel <= 8) do_acc(1'b0, 1'b1, 8'h00, $urandom_range(0, 3), pl);
      else               do_acc(1'b1, 1'b1, 8'h00, 0, pl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
